// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues instruction memory reads, absorbs the 1-cycle read latency,
// buffers words in a prefetch queue and supports redirect/flush. HALT detection: IFU_HALT_DETECT_EN.
module instruction_fetch_unit #(
    parameter int word_size   = 32,
    parameter int addr_width  = 6,
    parameter int queue_depth = 4,
    parameter int reset_pc    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [addr_width-1:0]         imem_addr,
    output logic                          imem_en,
    input  logic [word_size-1:0]          imem_rdata,
    output logic                          inst_valid,
    output logic [word_size-1:0]          inst_data,
    output logic [addr_width-1:0]         inst_pc,
    input  logic                          inst_ready,
    input  logic                          redirect_valid,
    input  logic [addr_width-1:0]         redirect_pc,
    output logic [$clog2(queue_depth):0]  q_count,
    output logic                          halted
);

    localparam int ptr_w = $clog2(queue_depth);
    localparam int cnt_w = ptr_w + 1;
    localparam logic [addr_width-1:0] reset_addr = addr_width'(reset_pc);
    localparam logic [cnt_w-1:0]      full_count = cnt_w'(queue_depth);

    logic [addr_width-1:0] fetch_pc;
    logic [addr_width-1:0] inflight_pc;
    logic                  inflight;
    logic                  halted_q;
    logic [ptr_w-1:0]      rd_ptr;
    logic [ptr_w-1:0]      wr_ptr;
    logic [cnt_w-1:0]      count;
    logic [cnt_w-1:0]      occupancy;
    logic                  push;
    logic                  pop;
    logic                  halt_word;

    logic [word_size-1:0]  q_data [queue_depth];
    logic [addr_width-1:0] q_pc   [queue_depth];

`ifdef IFU_HALT_DETECT_EN
    assign halt_word = (imem_rdata[word_size-1 -: 5] == 5'h1f);
`else
    assign halt_word = 1'b0;
`endif

    // Slots already promised to an in-flight read count as occupied, so a push never
    // finds the queue full.
    assign occupancy = count + cnt_w'(inflight);
    assign imem_en   = rst && !redirect_valid && !halted_q && (occupancy < full_count);
    assign imem_addr = fetch_pc;

    // Decode handshake: the head transfers on a cycle where inst_valid && inst_ready are
    // both high; while inst_valid && !inst_ready the head word and pc stay unchanged.
    // A redirect in the same cycle overrides both the pop and any arriving response.
    assign push = inflight && !redirect_valid && !halted_q;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? q_data[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? q_pc[rd_ptr] : '0;
    assign q_count    = count;
    assign halted     = halted_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= reset_addr;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            halted_q    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            halted_q <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                fetch_pc    <= fetch_pc + addr_width'(1);
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
                if (halt_word) halted_q <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + ptr_w'(1);
            count <= count + cnt_w'(push) - cnt_w'(pop);
        end
    end

    // Payload storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory model, driver tasks,
// expected-queue scoreboard fed at every reset/redirect, and a decoupled monitor.
module tb_instruction_fetch_unit;
  localparam int WS = 32;
  localparam int AW = 6;
  localparam int QD = 4;
  localparam int CW = 3;
  localparam int EW = AW + WS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [WS-1:0] imem_rdata;
  logic          inst_valid;
  logic [WS-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [CW-1:0] q_count;
  logic          halted;

  logic [WS-1:0] mem [64];
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  instruction_fetch_unit #(
    .word_size(WS), .addr_width(AW), .queue_depth(QD), .reset_pc(0)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .q_count(q_count), .halted(halted)
  );

  // clock / memory model with a one-cycle read latency
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: after a (re)start at pc, decode sees pc, pc+1, ... (mod 64) with mem data
  task automatic set_expect(input logic [AW-1:0] pc, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc, mem[pc]});
      pc = pc + 1'b1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // first valid instruction appears after exactly two edges
  task automatic check_start(input logic [AW-1:0] pc);
    @(negedge clk);
    check("start_gap0", 64'(inst_valid), 64'd0);
    @(negedge clk);
    check("start_gap1", 64'(inst_valid), 64'd0);
    @(negedge clk);
    check("start_valid", 64'(inst_valid), 64'd1);
    check("start_pc", 64'(inst_pc), 64'(pc));
  endtask

  // entered at posedge+1; reset asserted between edges
  task automatic do_reset(input int n);
    #2;
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_data", 64'(inst_data), 64'd0);
    check("rst_pc", 64'(inst_pc), 64'd0);
    check("rst_count", 64'(q_count), 64'd0);
    check("rst_en", 64'(imem_en), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    tick(2);
    set_expect('0, n);
    rst = 1'b1;
    check_start('0);
    tick(1);
  endtask

  task automatic redirect(input logic [AW-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    set_expect(pc, 256);
    tick(1);
    redirect_valid = 1'b0;
    check_start(pc);
    tick(1);
  endtask

  // monitor: pops the scoreboard on every accepted handshake
  logic          prev_hold = 1'b0;
  logic [WS-1:0] prev_data;
  logic [AW-1:0] prev_pc;
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      check("valid_vs_count", 64'(inst_valid), 64'(q_count != '0));
      check("count_range", 64'(q_count <= CW'(QD)), 64'd1);
      if (prev_hold) begin
        check("hold_data", 64'(inst_data), 64'(prev_data));
        check("hold_pc", 64'(inst_pc), 64'(prev_pc));
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got pc %0d data %0h expected none", inst_pc, inst_data);
        end else begin
          e = exp_q.pop_front();
          check("deliver", 64'({inst_pc, inst_data}), 64'(e));
        end
      end
      prev_hold = inst_valid && !inst_ready && !redirect_valid;
      prev_data = inst_data;
      prev_pc   = inst_pc;
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = WS'(i + 100);
    tick(1);

    // streaming from reset
    inst_ready = 1'b1;
    do_reset(256);
    tick(10);
    check("stream_progress", 64'(exp_q.size() <= 256 - 9), 64'd1);

    // backpressure: queue saturates, fetch stops, head holds
    inst_ready = 1'b0;
    do_reset(256);
    tick(9);
    check("sat_count", 64'(q_count), 64'(QD));
    check("sat_en", 64'(imem_en), 64'd0);
    check("sat_head_data", 64'(inst_data), 64'd100);
    check("sat_head_pc", 64'(inst_pc), 64'd0);
    inst_ready = 1'b1;
    tick(8);
    check("sat_drain", 64'(exp_q.size()), 64'(256 - 8));

    // address wrap 62, 63, 0, 1
    redirect(6'd62);
    tick(6);
    check("wrap_progress", 64'(exp_q.size() <= 256 - 5), 64'd1);

    // redirect with three entries queued and one read in flight
    inst_ready = 1'b0;
    do_reset(256);
    tick(1);
    check("pre_redir_count", 64'(q_count), 64'd3);
    redirect(6'd20);
    inst_ready = 1'b1;
    tick(6);

    // randomized traffic with random redirects and occasional resets
    for (int i = 0; i < 64; i++) mem[i] = $urandom() & 32'h7fff_ffff;
    do_reset(256);
    for (int seg = 0; seg < 30; seg++) begin
      if ($urandom_range(0, 5) == 0) do_reset(256);
      else redirect(AW'($urandom_range(0, 63)));
      repeat ($urandom_range(10, 60)) begin
        inst_ready = ($urandom_range(0, 3) != 0);
        tick(1);
      end
    end

    // HALT opcode word at address 5
    inst_ready = 1'b1;
    mem[5] = 32'hf800_0005;
`ifdef IFU_HALT_DETECT_EN
    do_reset(6);
    tick(20);
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_en", 64'(imem_en), 64'd0);
    check("halt_drained", 64'(exp_q.size()), 64'd0);
    check("halt_valid", 64'(inst_valid), 64'd0);
    mem[5] = 32'd105;
    redirect('0);
    check("halt_cleared", 64'(halted), 64'd0);
    tick(10);
    check("halt_resume", 64'(halted), 64'd0);
`else
    do_reset(256);
    tick(20);
    check("nohalt_flag", 64'(halted), 64'd0);
    check("nohalt_continue", 64'(exp_q.size() <= 256 - 19), 64'd1);
`endif
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
